// File: rtl/seg7_scan_ctrl_if.sv
// Digit-source / display-pin bundle for the 7-segment scan controller.
// master = BCD producer side, slave = scan controller.
interface seg7_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic               en;
  logic               load;
  logic [4*N_DIG-1:0] digits;
  logic               lz_blank;
  logic [6:0]         seg;
  logic [N_DIG-1:0]   an;
  logic               frame_done;

  modport master (
    output en, load, digits, lz_blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, load, digits, lz_blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-seg scanner with double-buffered BCD and blanking gaps.
// Registered outputs change on the state edge; load is always accepted, no backpressure.
module seg7_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int PRESC     = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic         clk,
  input logic         rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int MAXC = (PRESC > BLANK_CYC) ? PRESC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(N_DIG);
  localparam logic [CW-1:0]      SHOW_LAST  = CW'(PRESC - 1);
  localparam logic [CW-1:0]      BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0]      IDX_LAST   = IW'(N_DIG - 1);
  localparam logic [4*N_DIG-1:0] BLANK_WORD = {N_DIG{4'hF}};

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [4*N_DIG-1:0] act_q, act_d;
  logic [4*N_DIG-1:0] pend_q, pend_d;
  logic               pv_q, pv_d;
  logic [6:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic               fd_q, fd_d;
  logic               frame_start;
  logic               show_entry;
  logic               wrap;
  logic [3:0]         dig;

  function automatic logic [6:0] dec_7seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A zero digit is a leading zero when every more-significant digit is zero or non-BCD.
  function automatic logic lz_sup(input logic [4*N_DIG-1:0] w, input logic [IW-1:0] k);
    logic sup;
    sup = (k != '0);
    for (int j = 0; j < N_DIG; j++) begin
      if (IW'(j) == k && w[4*j +: 4] != 4'd0)
        sup = 1'b0;
      if (IW'(j) > k && w[4*j +: 4] != 4'd0 && w[4*j +: 4] <= 4'd9)
        sup = 1'b0;
    end
    return sup;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= BLANK_WORD;
      pend_q  <= BLANK_WORD;
      pv_q    <= 1'b0;
      seg_q   <= 7'b1111111;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_start = 1'b0;
    show_entry  = 1'b0;
    wrap        = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_start = 1'b1;
          idx_d       = '0;
          cnt_d       = '0;
          if (BLANK_CYC == 0) begin
            state_d    = SHOW;
            show_entry = 1'b1;
          end else begin
            state_d = BLANK;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d    = SHOW;
            cnt_d      = '0;
            show_entry = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              wrap        = 1'b1;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
            if (BLANK_CYC == 0) begin
              state_d    = SHOW;
              show_entry = 1'b1;
            end else begin
              state_d = BLANK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Active only moves at a frame start; a coincident load bypasses pending.
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    if (frame_start && bus.load) begin
      act_d = bus.digits;
      pv_d  = 1'b0;
    end else begin
      if (frame_start && pv_q) begin
        act_d = pend_q;
        pv_d  = 1'b0;
      end
      if (bus.load) begin
        pend_d = bus.digits;
        pv_d   = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    fd_d  = wrap;
    dig   = 4'hF;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_d == IW'(k))
        dig = act_d[4*k +: 4];
    end
    if (state_d != SHOW) begin
      seg_d = 7'b1111111;
      an_d  = '1;
    end else if (show_entry) begin
      // Slot contents are latched here so lz_blank is only sampled once per slot.
      if (bus.lz_blank && lz_sup(act_d, idx_d)) begin
        seg_d = 7'b1111111;
        an_d  = '1;
      end else begin
        seg_d        = dec_7seg(dig);
        an_d         = '1;
        an_d[idx_d]  = 1'b0;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + randomized bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int N_DIG     = 4;
  localparam int PRESC     = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = PRESC + BLANK_CYC;
  localparam int FRAME     = N_DIG * SLOT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.N_DIG(N_DIG)) bus ();

  seg7_scan_ctrl #(
    .N_DIG(N_DIG), .PRESC(PRESC), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: scan position is a cycle count since the scan started.
  bit               running;
  int               t;
  logic [3:0]       act [N_DIG];
  logic [3:0]       pend[N_DIG];
  bit               pv;
  bit               lz_slot;
  logic [6:0]       e_seg;
  logic [N_DIG-1:0] e_an;
  logic             e_fd;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    if (d > 4'd9) return 7'b1111111;
    return tbl[d];
  endfunction

  task automatic model_edge();
    bit fs, wr, sup;
    int slot, w;
    fs = 0; wr = 0;
    if (!rst_n) begin
      running = 0;
      pv      = 0;
      for (int k = 0; k < N_DIG; k++) begin act[k] = 4'hF; pend[k] = 4'hF; end
      e_seg = 7'b1111111; e_an = '1; e_fd = 1'b0;
      return;
    end
    if (!bus.en) begin
      running = 0;
    end else if (!running) begin
      running = 1; t = 0; fs = 1;
    end else begin
      t++;
      fs = (t % FRAME == 0);
      wr = fs;
    end
    if (fs && bus.load) begin
      for (int k = 0; k < N_DIG; k++) act[k] = bus.digits[4*k +: 4];
      pv = 0;
    end else begin
      if (fs && pv) begin
        for (int k = 0; k < N_DIG; k++) act[k] = pend[k];
        pv = 0;
      end
      if (bus.load) begin
        for (int k = 0; k < N_DIG; k++) pend[k] = bus.digits[4*k +: 4];
        pv = 1;
      end
    end
    e_fd  = wr;
    e_seg = 7'b1111111;
    e_an  = '1;
    if (running) begin
      slot = (t % FRAME) / SLOT;
      w    = t % SLOT;
      if (w == BLANK_CYC) lz_slot = bus.lz_blank;
      if (w >= BLANK_CYC) begin
        sup = lz_slot && slot > 0 && act[slot] == 4'd0;
        for (int j = slot + 1; j < N_DIG; j++)
          if (act[j] != 4'd0 && act[j] <= 4'd9) sup = 0;
        if (!sup) begin
          e_seg = glyph(act[slot]);
          e_an[slot] = 1'b0;
        end
      end
    end
  endtask

  task automatic check();
    ncmp++;
    assert (bus.seg === e_seg) else begin
      nfail++; $error("FAIL seg t=%0d: got %b exp %b", t, bus.seg, e_seg);
    end
    ncmp++;
    assert (bus.an === e_an) else begin
      nfail++; $error("FAIL an t=%0d: got %b exp %b", t, bus.an, e_an);
    end
    ncmp++;
    assert (bus.frame_done === e_fd) else begin
      nfail++; $error("FAIL frame_done t=%0d: got %b exp %b", t, bus.frame_done, e_fd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the model sits at the given frame position (bounded).
  task automatic align(input int pos);
    for (int i = 0; i < FRAME + 1 && !(running && (t % FRAME) == pos); i++) tick();
  endtask

  task automatic pin_check(input string tag, input logic [N_DIG-1:0] an_x, input logic [6:0] seg_x);
    ncmp++;
    assert (bus.an === an_x && bus.seg === seg_x) else begin
      nfail++; $error("FAIL %s: got an=%b seg=%b exp an=%b seg=%b", tag, bus.an, bus.seg, an_x, seg_x);
    end
  endtask

  task automatic load_word(input logic [4*N_DIG-1:0] v);
    bus.load = 1'b1; bus.digits = v;
    tick();
    bus.load = 1'b0;
  endtask

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(1, 0) == 0) return 4'd0;
    return 4'($urandom_range(15, 0));
  endfunction

  initial begin
    // Reset with en and load asserted: must stay dark and capture nothing.
    rst_n = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.digits = 16'h1234; bus.lz_blank = 1'b0;
    run(3);
    pin_check("reset_dark", 4'b1111, 7'b1111111);
    rst_n = 1'b1; bus.load = 1'b0;
    run(FRAME + 2);

    // Load while idle, then scan 1234.
    bus.en = 1'b0;
    run(2);
    load_word(16'h1234);
    bus.en = 1'b1;
    run(3);
    pin_check("first_slot_4", 4'b1110, 7'b1001100);
    run(2 * FRAME);

    // Leading-zero suppression on 0070, then without suppression.
    load_word(16'h0070);
    bus.lz_blank = 1'b1;
    run(2 * FRAME);
    align(2 * SLOT + BLANK_CYC);
    pin_check("lz_idx2_dark", 4'b1111, 7'b1111111);
    bus.lz_blank = 1'b0;
    run(2 * FRAME);

    // Mid-frame load must not disturb the running frame.
    load_word(16'h1234);
    run(FRAME);
    align(SLOT + BLANK_CYC + 1);
    load_word(16'h5678);
    run(2 * FRAME);

    // Load exactly on the frame-start edge goes straight to active.
    align(FRAME - 1);
    load_word(16'h9012);
    run(FRAME);

    // Drop en during idx2 show, then resume.
    align(2 * SLOT + BLANK_CYC + 1);
    bus.en = 1'b0;
    tick();
    pin_check("en_drop_dark", 4'b1111, 7'b1111111);
    run(3);
    bus.en = 1'b1;
    run(FRAME + 3);

    // Non-BCD digit still drives its anode; mixed suppression case.
    load_word(16'h12B4);
    run(2 * FRAME);
    load_word(16'h0B00);
    bus.lz_blank = 1'b1;
    run(2 * FRAME);
    bus.lz_blank = 1'b0;

    // Reset during idx3 show clears the buffers.
    align(3 * SLOT + BLANK_CYC + 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(FRAME + 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.load   = ($urandom_range(7, 0) == 0);
      bus.digits = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()};
      if ($urandom_range(15, 0) == 0) bus.lz_blank = ~bus.lz_blank;
      bus.en = ($urandom_range(59, 0) != 0);
      rst_n  = ($urandom_range(149, 0) != 0);
      tick();
    end
    bus.load = 1'b0; bus.en = 1'b1; rst_n = 1'b1;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display. A single dec_7seg decoder instance is shared across all digits. The block holds a double-buffered BCD word, steps one digit per slot and drives active-low anode selects. A blanking gap between slots suppresses ghosting, and optional leading-zero suppression is provided. It sits between the counter/datapath that produces BCD values and the board display pins.

Parameters:
N_DIG, 4, number of digits (>=2); digit 0 is least significant.
PRESC, 50000, clock cycles a digit is lit per slot (>=1).
BLANK_CYC, 16, clock cycles all anodes are off before each slot (>=0; 0 removes the BLANK state).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  scan enable; 0 forces display dark
load  input  1  one-cycle strobe capturing digits into pending buffer
digits  input  4*N_DIG  packed BCD, digit k at [4k+3:4k]
lz_blank  input  1  1 = suppress leading zeros
seg  output  7  segments ABCDEFG, active-low (0 = lit), registered
an  output  N_DIG  anode selects, active-low, registered
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n, sampled on the clk rising edge.
- Reset (rst_n=0 at an edge, including mid-operation): state=IDLE, idx=0, slot counter=0, seg=7'b1111111, an=all 1, frame_done=0, active and pending buffers=all 4'hF (blank code), pending_valid=0.
- Buffers:
  - load=1 captures digits into pending and sets pending_valid.
  - At every frame start (entry into BLANK with idx=0, from IDLE or from wrap), active<=pending and pending_valid is cleared, provided pending_valid=1.
  - If load coincides with a frame-start edge, the new digits go directly into active (bypass) and pending_valid ends 0.
  - A load mid-frame never alters the current frame.
- States:
  - IDLE: outputs dark. When en=1, go to BLANK with idx=0 (frame start).
  - BLANK: an=all 1, seg=7'b1111111 for BLANK_CYC cycles, then go to SHOW with the same idx. If BLANK_CYC=0, go straight to SHOW.
  - SHOW: an[idx]=0 and all other anodes 1; seg=dec_7seg(active[idx]) for PRESC cycles.
  - End of SHOW: if idx<N_DIG-1, idx++ and go to BLANK. If idx=N_DIG-1, idx=0, go to BLANK, frame start, and frame_done=1 for exactly the cycle after that edge.
- Outputs are registered and change on the same edge as the state/idx change.
- Frame period is N_DIG*(PRESC+BLANK_CYC) cycles.
- en=0 at any edge: next state IDLE, idx=0, counters cleared, outputs dark, no frame_done. Buffers are retained.
- Digit codes 10-15 decode to 7'b1111111 (dark digit); the anode is still driven in SHOW.
- Leading-zero suppression (lz_blank=1): digit k>0 is suppressed when active[k]=0 and every active[j], j>k, is 0 or a code >9. A suppressed digit shows seg=all 1 and an=all 1 for its SHOW slot. Digit 0 is never suppressed. Suppression is evaluated on active, so it changes only at a frame start. lz_blank itself is sampled per slot.
- Slot counter width is clog2(max(PRESC,BLANK_CYC)+1). No overflow is possible.

Test Plan:
Use N_DIG=4, PRESC=4, BLANK_CYC=2 unless stated.
1. rst_n=0 for 3 cycles with en=1, load=1 -> seg=1111111, an=1111, frame_done=0 each cycle. After release with en=1, the first frame shows blank code (all dark) on every slot.
2. load digits=16'h1234, then en=1 -> 2 dark cycles, then an=1110 with seg=1001100 for 4 cycles; 2 dark; an=1101 with 0000110; an=1011 with 0010010; an=0111 with 1001111. frame_done pulses every 24 cycles.
3. digits=16'h0070 with lz_blank=1 -> idx0 an=1110 with 0000001, idx1 an=1101 with 0001111, idx2 and idx3 dark (an=1111). With lz_blank=0 -> idx2 an=1011 and idx3 an=0111, both seg=0000001.
4. Running 16'h1234, load 16'h5678 during idx1 SHOW -> idx2 and idx3 still show 2 and 1. The next frame shows 8,7,6,5. Also: load on the frame-start edge -> that same frame shows the new value.
5. en drop during idx2 SHOW -> next edge an=1111 and seg=1111111, no frame_done. Re-raise en -> 2 dark cycles, then idx0, with the buffer retained.
6. Digit 1 = 4'hB -> slot 1 an=1101 with seg=1111111. Also: rst_n=0 during idx3 SHOW -> dark on the next edge and buffers reset to blank.
